// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the handshaked sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_BIC  = 4'b0101,
        OP_MVN  = 4'b0110,
        OP_LSL  = 4'b0111,
        OP_LSR  = 4'b1000,
        OP_ASR  = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_UDIV = 4'b1011,
        OP_UMOD = 4'b1100
    } alu_op_t;

    // Bit positions inside the 4-bit {N,Z,C,V} flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide/modulo,
// one bit per cycle, N iterations after start.
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  alu_op_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    // acc: product (MUL) or partial remainder (UDIV/UMOD)
    // x:   shifted multiplicand (MUL) or dividend/quotient (UDIV/UMOD)
    // y:   shifted multiplier (MUL) or divisor (UDIV/UMOD)
    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    alu_op_t       op_q, op_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N:0]    rem_sh;
    logic [N:0]    rem_diff;

    // Next-state: load on start, otherwise step one iteration while running
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        done     = 1'b0;
        rem_sh   = {acc_q, x_q[N-1]};
        rem_diff = rem_sh - {1'b0, y_q};
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            op_d  = op;
            acc_d = '0;
            x_d   = a;
            y_d   = b;
        end else if (run_q) begin
            if (op_q == OP_MUL) begin
                if (y_q[0]) acc_d = acc_q + x_q;
                x_d = x_q << 1;
                y_d = y_q >> 1;
            end else if (rem_sh >= {1'b0, y_q}) begin
                acc_d = rem_diff[N-1:0];
                x_d   = {x_q[N-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[N-1:0];
                x_d   = {x_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    // Result reflects the final iteration so the top can capture it on the done edge
    assign result = (op_q == OP_UDIV) ? x_d : acc_d;

    // Engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            op_q  <= OP_MUL;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops registered at accept, MUL/UDIV/UMOD
// through the iterative engine; NZCV flags travel with each result.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    state_t       state_q, state_d;
    logic [N-1:0] res_q, res_d;
    logic [3:0]   flg_q, flg_d;

    alu_op_t      op;
    logic         accept;
    logic         is_iter;
    logic         start;
    logic         it_done;
    logic [N-1:0] it_res;

    logic [N:0]   sum, diff;
    logic [7:0]   amt;
    logic         amt_big;
    logic [N-1:0] sc_res;
    logic         sc_c, sc_v, sc_illegal;
    logic [3:0]   sc_flg;

    assign op        = alu_op_t'(ALUControl);
    assign out_valid = (state_q == HOLD);
    assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign is_iter   = (op == OP_MUL) | (((op == OP_UDIV) | (op == OP_UMOD)) & (B != '0));
    assign result    = res_q;
    assign flags     = flg_q;

    // Single-cycle datapath and flags, including the divide-by-zero shortcut
    always_comb begin
        sc_res     = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_illegal = 1'b0;
        sum        = {1'b0, A} + {1'b0, B};
        diff       = {1'b0, A} - {1'b0, B};
        amt        = B[7:0];
        amt_big    = (32'(amt) >= 32'(N));
        case (op)
            OP_ADD: begin
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (A[N-1] == B[N-1]) & (sum[N-1] != A[N-1]);
            end
            OP_SUB: begin
                sc_res = diff[N-1:0];
                sc_c   = ~diff[N];
                sc_v   = (A[N-1] != B[N-1]) & (diff[N-1] != A[N-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_BIC:  sc_res = A & ~B;
            OP_MVN:  sc_res = ~B;
            OP_LSL:  sc_res = amt_big ? '0 : (A << amt);
            OP_LSR:  sc_res = amt_big ? '0 : (A >> amt);
            OP_ASR:  sc_res = amt_big ? {N{A[N-1]}} : N'($signed(A) >>> amt);
            OP_MUL:  sc_res = '0;
            OP_UDIV: begin
                sc_res = '1;
                sc_v   = 1'b1;
            end
            OP_UMOD: begin
                sc_res = A;
                sc_v   = 1'b1;
            end
            default: sc_illegal = 1'b1;
        endcase
        sc_flg = '0;
        if (!sc_illegal) begin
            sc_flg[FLAG_N] = sc_res[N-1];
            sc_flg[FLAG_Z] = (sc_res == '0);
            sc_flg[FLAG_C] = sc_c;
            sc_flg[FLAG_V] = sc_v;
        end
    end

    // FSM next-state and output-slot loading
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flg_d   = flg_q;
        start   = 1'b0;
        if (accept) begin
            if (is_iter) begin
                state_d = BUSY;
                start   = 1'b1;
            end else begin
                state_d = HOLD;
                res_d   = sc_res;
                flg_d   = sc_flg;
            end
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end else if (state_q == BUSY && it_done) begin
            state_d       = HOLD;
            res_d         = it_res;
            flg_d         = '0;
            flg_d[FLAG_N] = it_res[N-1];
            flg_d[FLAG_Z] = (it_res == '0);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    alu_iter_muldiv #(.N(N)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (A),
        .b      (B),
        .done   (it_done),
        .result (it_res)
    );

endmodule
